// File: rtl/ena_gen_nch.sv
// ena_gen_nch: base tick divider, NCH derived enable channels, selectable output.
// Ports: ckht/rst clock and async reset; run, clr, sw, mode, trig controls;
// ena_base, ena_ch, ena_sel pulses; busy = one-shot armed.
module ena_gen_nch #(
  parameter int BASE_DIV = 50000,
  parameter int NCH      = 4,
  parameter int SEL_W    = 2,
  parameter int DIV_W    = 16,
  parameter logic [NCH*DIV_W-1:0] DIV_LIST =
    {16'd10, 16'd20, 16'd50, 16'd1000}
) (
  input  logic             ckht,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [SEL_W-1:0] sw,
  input  logic             mode,
  input  logic             trig,
  output logic             ena_base,
  output logic [NCH-1:0]   ena_ch,
  output logic             ena_sel,
  output logic             busy
);

  localparam int CW = $clog2(BASE_DIV);
  localparam logic [CW-1:0] BLAST = CW'(BASE_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } state_t;

  logic [CW-1:0]    r_bcnt;
  logic             r_ena_base;
  logic             w_tick;
  logic [NCH-1:0]   w_ch_raw;
  logic [NCH-1:0]   w_ena_ch;
  logic [SEL_W-1:0] r_sw_s1;
  logic [SEL_W-1:0] r_sw_s2;
  logic [SEL_W-1:0] r_sel;
  logic [31:0]      w_sel32;
  logic             w_selp;
  logic             w_armed;
  state_t           r_state;
  state_t           w_next;

  assign w_tick = run & (r_bcnt == BLAST);

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      r_bcnt     <= '0;
      r_ena_base <= 1'b0;
    end else begin
      r_ena_base <= w_tick & ~clr;
      if (clr) begin
        r_bcnt <= '0;
      end else if (run) begin
        r_bcnt <= w_tick ? '0 : r_bcnt + CW'(1);
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [DIV_W-1:0] LAST =
      DIV_LIST[k*DIV_W +: DIV_W] - DIV_W'(1);

    logic [DIV_W-1:0] r_ccnt;
    logic             r_pulse;
    logic             w_last;

    assign w_last      = (r_ccnt == LAST);
    assign w_ch_raw[k] = r_pulse;

    always_ff @(posedge ckht or posedge rst) begin
      if (rst) begin
        r_ccnt  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_tick & w_last & ~clr;
        if (clr) begin
          r_ccnt <= '0;
        end else if (w_tick) begin
          r_ccnt <= w_last ? '0 : r_ccnt + DIV_W'(1);
        end
      end
    end
  end

  // Pulses are registered off a run-qualified tick; the extra
  // gate keeps them low as soon as run drops mid-cycle.
  assign ena_base = r_ena_base & run;
  assign w_ena_ch = w_ch_raw & {NCH{run}};
  assign ena_ch   = w_ena_ch;

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_sel   <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_sel   <= r_sw_s2;
    end
  end

  // Compared at 32 bits so a select beyond NCH matches nothing.
  assign w_sel32 = 32'(r_sel);

  always_comb begin
    w_selp = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sel32 == 32'(i)) begin
        w_selp = w_ena_ch[i];
      end
    end
  end

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!mode) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (trig)   w_next = S_ARMED;
        S_ARMED: if (w_selp) w_next = S_IDLE;
      endcase
    end
  end

  assign w_armed = (r_state == S_ARMED);
  assign ena_sel = mode ? (w_armed & w_selp) : w_selp;
  assign busy    = w_armed & mode;

endmodule

// File: tb/tb_ena_gen_nch.sv
// tb_ena_gen_nch: random stimulus against a tick-count reference model.
// Checks every output each cycle plus first-pulse timing after reset.
module tb_ena_gen_nch;

  localparam int BD  = 4;
  localparam int NCH = 4;
  localparam int SW  = 2;
  localparam int DW  = 16;
  localparam logic [NCH*DW-1:0] DL =
    {16'd1, 16'd2, 16'd3, 16'd5};

  int divk [NCH] = '{5, 3, 2, 1};

  logic          ckht = 1'b0;
  logic          rst  = 1'b1;
  logic          run  = 1'b0;
  logic          clr  = 1'b0;
  logic [SW-1:0] sw   = '0;
  logic          mode = 1'b0;
  logic          trig = 1'b0;
  logic          ena_base;
  logic [NCH-1:0] ena_ch;
  logic          ena_sel;
  logic          busy;

  ena_gen_nch #(
    .BASE_DIV (BD),
    .NCH      (NCH),
    .SEL_W    (SW),
    .DIV_W    (DW),
    .DIV_LIST (DL)
  ) dut (
    .ckht     (ckht),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .sw       (sw),
    .mode     (mode),
    .trig     (trig),
    .ena_base (ena_base),
    .ena_ch   (ena_ch),
    .ena_sel  (ena_sel),
    .busy     (busy)
  );

  always #5 ckht = ~ckht;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Model: active ticks since reset/clear; pulses follow by modulo.
  longint         m_n;
  logic           m_pb;
  logic [NCH-1:0] m_pch;
  int             swq[$];
  logic           m_armed;

  function automatic void m_reset();
    m_n     = 0;
    m_pb    = 1'b0;
    m_pch   = '0;
    swq     = '{0, 0, 0};
    m_armed = 1'b0;
  endfunction

  function automatic void m_out(output logic eb,
                                output logic [NCH-1:0] ech,
                                output logic es,
                                output logic bz);
    logic selp;
    eb   = m_pb & run;
    ech  = m_pch & {NCH{run}};
    selp = (swq[0] < NCH) ? ech[swq[0]] : 1'b0;
    es   = mode ? (m_armed & selp) : selp;
    bz   = m_armed & mode;
  endfunction

  function automatic void m_edge();
    logic eb, es, bz;
    logic [NCH-1:0] ech;
    logic pass;
    m_out(eb, ech, es, bz);
    pass = mode & es;
    if (rst) begin
      m_reset();
      return;
    end
    swq.push_back(int'(sw));
    void'(swq.pop_front());
    if (clr) begin
      m_n   = 0;
      m_pb  = 1'b0;
      m_pch = '0;
    end else if (run) begin
      m_n++;
      m_pb = (m_n % BD == 0);
      for (int k = 0; k < NCH; k++)
        m_pch[k] = (m_n % (BD * divk[k]) == 0);
    end else begin
      m_pb  = 1'b0;
      m_pch = '0;
    end
    if (!mode)        m_armed = 1'b0;
    else if (!m_armed) m_armed = trig;
    else if (pass)    m_armed = 1'b0;
  endfunction

  task automatic check_all();
    logic eb, es, bz;
    logic [NCH-1:0] ech;
    m_out(eb, ech, es, bz);
    chk("ena_base", ena_base, eb);
    chk("ena_ch",   ena_ch,   ech);
    chk("ena_sel",  ena_sel,  es);
    chk("busy",     busy,     bz);
  endtask

  int first_b;
  int first_c0;
  int rst_left;

  initial begin
    m_reset();
    repeat (3) @(posedge ckht);
    #1;
    check_all();
    rst = 1'b0;
    run = 1'b1;
    first_b  = 0;
    first_c0 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge ckht);
      m_edge();
      #1;
      check_all();
      if (ena_base  && first_b  == 0) first_b  = c;
      if (ena_ch[0] && first_c0 == 0) first_c0 = c;
    end
    chk("first_base", first_b, 4);
    chk("first_ch0", first_c0, 20);

    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge ckht);
      m_edge();
      #1;
      check_all();
      run  = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      trig = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) sw = SW'($urandom_range(0, 3));
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        rst_left = 1;
        m_reset();
        #1;
        chk("rst_async_base", ena_base, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        check_all();
      end else begin
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
